// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial core: opcode and sequencer state
// encodings plus the default word width used by the GPR, ALU and sequencer.
package serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_HALT = 2'b01,
        OP_ADD  = 2'b10,
        OP_LOAD = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for one serial pass.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clr         force count to 0 (wins over i_en)
//   i_en          advance count by one, wrapping at WIDTH
//   o_count       current bit index
//   o_last        count is at WIDTH-1
module bit_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_last
);

    logic [CW-1:0] count_q;

    // WIDTH is a power of two, so natural CW-bit overflow gives the wrap to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_clr) begin
            count_q <= '0;
        end else if (i_en) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign o_count = count_q;
    assign o_last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_ctrl.sv
// Fetch/execute sequencer for the bit-serial core. Handshakes one opcode
// from instruction memory, then drives the GPR/mux/PC controls for a
// WIDTH-bit pass (LOAD/ADD) or a single cycle (NOP). HALT parks until reset.
// Optional build macro: SERIAL_CTRL_STEP_EN adds i_step for single-stepping.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_run                     allow fetching (sampled in IDLE and last EXEC cycle)
//   i_step                    (SERIAL_CTRL_STEP_EN only) one-shot fetch from IDLE
//   o_fetch_req, i_fetch_ack  instruction fetch handshake, i_instr valid on ack
//   o_bit_sel                 current bit index for datapath muxes
//   o_con_*                   datapath controls, o_carry_clr clears ALU carry
//   o_busy, o_halted          status decodes of the state
// All outputs are decodes of state/opcode/counter only.
module serial_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
`ifdef SERIAL_CTRL_STEP_EN
    input  logic          i_step,
`endif
    output logic          o_fetch_req,
    input  logic          i_fetch_ack,
    input  logic [1:0]    i_instr,
    output logic [CW-1:0] o_bit_sel,
    output logic          o_con_mux,
    output logic          o_con_muxalu,
    output logic          o_con_gpr_region,
    output logic          o_con_gpr_write,
    output logic          o_con_gpr_shift,
    output logic          o_con_pcincr,
    output logic          o_carry_clr,
    output logic          o_busy,
    output logic          o_halted
);

    state_e        state_q;
    state_e        state_d;
    opcode_e       opcode_q;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_last;
    logic [CW-1:0] cnt;
    logic          start;
    logic          exec_done;
    logic          fetch_take;

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (cnt_clr),
        .i_en    (cnt_en),
        .o_count (cnt),
        .o_last  (cnt_last)
    );

    // Leaving IDLE: i_run, or a single-step request when that feature is built.
`ifdef SERIAL_CTRL_STEP_EN
    assign start = i_run | i_step;
`else
    assign start = i_run;
`endif

    assign fetch_take = (state_q == ST_FETCH) && i_fetch_ack;

    // NOP finishes in one cycle; LOAD/ADD finish on the last bit of the pass.
    assign exec_done = (opcode_q == OP_NOP) ||
                       (((opcode_q == OP_ADD) || (opcode_q == OP_LOAD)) && cnt_last);

    // State and opcode registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_NOP;
        end else begin
            state_q <= state_d;
            if (fetch_take) begin
                opcode_q <= opcode_e'(i_instr);
            end
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_fetch_ack) begin
                    state_d = ST_EXEC;
                    cnt_clr = 1'b1;
                end
            end
            ST_EXEC: begin
                cnt_en = 1'b1;
                if (opcode_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (exec_done) begin
                    state_d = i_run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control decode from state, latched opcode and bit position.
    always_comb begin
        o_fetch_req      = 1'b0;
        o_con_mux        = 1'b0;
        o_con_muxalu     = 1'b0;
        o_con_gpr_region = 1'b0;
        o_con_gpr_write  = 1'b0;
        o_con_gpr_shift  = 1'b0;
        o_con_pcincr     = 1'b0;
        o_carry_clr      = 1'b0;
        o_busy           = 1'b0;
        o_halted         = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                o_fetch_req = 1'b1;
                o_busy      = 1'b1;
            end
            ST_EXEC: begin
                o_busy = 1'b1;
                unique case (opcode_q)
                    OP_NOP: begin
                        o_con_pcincr = 1'b1;
                    end
                    OP_LOAD: begin
                        o_con_mux       = 1'b1;
                        o_con_gpr_write = 1'b1;
                        o_con_gpr_shift = 1'b1;
                        o_con_pcincr    = cnt_last;
                    end
                    OP_ADD: begin
                        o_con_muxalu     = 1'b1;
                        o_con_gpr_region = 1'b1;
                        o_con_gpr_write  = 1'b1;
                        o_con_gpr_shift  = 1'b1;
                        o_con_pcincr     = cnt_last;
                        o_carry_clr      = (cnt == '0);
                    end
                    default: begin
                        o_con_pcincr = 1'b0;
                    end
                endcase
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_bit_sel = cnt;

endmodule

// File: tb/tb_serial_ctrl.sv
// Self-checking bench for serial_ctrl (WIDTH=8): expected control vectors are
// queued as stimulus is applied and popped after each clock edge.
module tb_serial_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    localparam logic [9:0] C_IDLE   = 10'b0000000000;
    localparam logic [9:0] C_FETCH  = 10'b1100000000;
    localparam logic [9:0] C_HALTED = 10'b0010000000;
    localparam logic [9:0] C_BUSY   = 10'b0100000000;
    localparam logic [9:0] C_LOAD   = 10'b0101001100;
    localparam logic [9:0] C_ADD    = 10'b0100111100;
    localparam logic [9:0] C_PC     = 10'b0000000010;
    localparam logic [9:0] C_CC     = 10'b0000000001;

    typedef struct packed {
        logic [9:0]    c;
        logic [CW-1:0] bs;
        logic          chk;
    } exp_t;

    logic          i_clk;
    logic          i_rst;
    logic          i_run;
`ifdef SERIAL_CTRL_STEP_EN
    logic          i_step;
`endif
    logic          o_fetch_req;
    logic          i_fetch_ack;
    logic [1:0]    i_instr;
    logic [CW-1:0] o_bit_sel;
    logic          o_con_mux;
    logic          o_con_muxalu;
    logic          o_con_gpr_region;
    logic          o_con_gpr_write;
    logic          o_con_gpr_shift;
    logic          o_con_pcincr;
    logic          o_carry_clr;
    logic          o_busy;
    logic          o_halted;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   pc_seen;

    serial_ctrl #(.WIDTH(W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_run            (i_run),
`ifdef SERIAL_CTRL_STEP_EN
        .i_step           (i_step),
`endif
        .o_fetch_req      (o_fetch_req),
        .i_fetch_ack      (i_fetch_ack),
        .i_instr          (i_instr),
        .o_bit_sel        (o_bit_sel),
        .o_con_mux        (o_con_mux),
        .o_con_muxalu     (o_con_muxalu),
        .o_con_gpr_region (o_con_gpr_region),
        .o_con_gpr_write  (o_con_gpr_write),
        .o_con_gpr_shift  (o_con_gpr_shift),
        .o_con_pcincr     (o_con_pcincr),
        .o_carry_clr      (o_carry_clr),
        .o_busy           (o_busy),
        .o_halted         (o_halted)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [9:0] ctl();
        return {o_fetch_req, o_busy, o_halted, o_con_mux, o_con_muxalu,
                o_con_gpr_region, o_con_gpr_write, o_con_gpr_shift,
                o_con_pcincr, o_carry_clr};
    endfunction

    function automatic exp_t mk(input logic [9:0] c, input int bs, input logic chk);
        exp_t e;
        e.c   = c;
        e.bs  = CW'(bs);
        e.chk = chk;
        return e;
    endfunction

    function automatic exp_t e_load(input int i);
        return mk(C_LOAD | ((i == W - 1) ? C_PC : C_IDLE), i, 1'b1);
    endfunction

    function automatic exp_t e_add(input int i);
        return mk(C_ADD | ((i == W - 1) ? C_PC : C_IDLE) | ((i == 0) ? C_CC : C_IDLE), i, 1'b1);
    endfunction

    // Advance one edge and sample 1 time unit later; tallies pcincr pulses.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_con_pcincr === 1'b1) pc_seen++;
    endtask

    task automatic test_reset();
        exp_t e;
        i_rst = 1'b1; i_run = 1'b0; i_fetch_ack = 1'b0; i_instr = 2'b00;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) i_rst = 1'b0;
            i_fetch_ack = c[0];      // stray acks in IDLE must be ignored
            i_instr     = 2'(c);
            exp_q.push_back(mk(C_IDLE, 0, 1'b1));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl() !== e.c || (e.chk && (o_bit_sel !== e.bs))) begin
                n_fail++;
                $display("FAIL reset c%0d: ctl=%b bit_sel=%0d, expected ctl=%b bit_sel=%0d",
                         c, ctl(), o_bit_sel, e.c, e.bs);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        i_run = 1'b1; i_fetch_ack = 1'b1; i_instr = 2'b11;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin i_fetch_ack = 1'b0; i_instr = 2'b00; end
            if (c == 0)      exp_q.push_back(mk(C_FETCH, 0, 1'b1));
            else if (c <= 8) exp_q.push_back(e_load(c - 1));
            else             exp_q.push_back(mk(C_FETCH, 0, 1'b1));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl() !== e.c || (e.chk && (o_bit_sel !== e.bs))) begin
                n_fail++;
                $display("FAIL load c%0d: ctl=%b bit_sel=%0d, expected ctl=%b bit_sel=%0d",
                         c, ctl(), o_bit_sel, e.c, e.bs);
            end
        end
    endtask

    // Enters already in FETCH; ack held off 3 cycles, i_run dropped mid-pass.
    task automatic test_add_delayed();
        exp_t e;
        for (int c = 0; c < 12; c++) begin
            i_fetch_ack = (c == 3);
            i_instr     = (c == 3) ? 2'b10 : 2'b01;
            i_run       = !(c >= 4 && c <= 10);
            if (c < 3)        exp_q.push_back(mk(C_FETCH, 0, 1'b1));
            else if (c <= 10) exp_q.push_back(e_add(c - 3));
            else              exp_q.push_back(mk(C_FETCH, 0, 1'b1));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl() !== e.c || (e.chk && (o_bit_sel !== e.bs))) begin
                n_fail++;
                $display("FAIL add c%0d: ctl=%b bit_sel=%0d, expected ctl=%b bit_sel=%0d",
                         c, ctl(), o_bit_sel, e.c, e.bs);
            end
        end
    endtask

    // NOP, NOP, HALT back to back, then 20 cycles of HALT under live inputs.
    task automatic test_nop_halt();
        exp_t e;
        i_run = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c < 5) begin
                i_fetch_ack = 1'b1;
                i_instr     = (c == 4) ? 2'b01 : 2'b00;
            end else begin
                i_fetch_ack = 1'($urandom_range(0, 1));
                i_instr     = 2'($urandom_range(0, 3));
            end
            if (c == 0 || c == 2)      exp_q.push_back(mk(C_BUSY | C_PC, 0, 1'b1));
            else if (c == 1 || c == 3) exp_q.push_back(mk(C_FETCH, 0, 1'b0));
            else if (c == 4)           exp_q.push_back(mk(C_BUSY, 0, 1'b1));
            else                       exp_q.push_back(mk(C_HALTED, 0, 1'b0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl() !== e.c || (e.chk && (o_bit_sel !== e.bs))) begin
                n_fail++;
                $display("FAIL nop_halt c%0d: ctl=%b bit_sel=%0d, expected ctl=%b bit_sel=%0d",
                         c, ctl(), o_bit_sel, e.c, e.bs);
            end
        end
        n_checks++;
        if (pc_seen !== 4) begin
            n_fail++;
            $display("FAIL pcincr_count: got %0d, expected 4", pc_seen);
        end
    endtask

    // Reset out of HALT, start a LOAD, reset again at bit 4.
    task automatic test_reset_mid();
        exp_t e;
        for (int c = 0; c < 10; c++) begin
            i_rst       = (c == 0 || c == 7);
            i_run       = (c >= 1 && c <= 7);
            i_fetch_ack = (c >= 1 && c <= 2);
            i_instr     = 2'b11;
            if (c == 0 || c >= 7) exp_q.push_back(mk(C_IDLE, 0, 1'b1));
            else if (c == 1)      exp_q.push_back(mk(C_FETCH, 0, 1'b1));
            else                  exp_q.push_back(e_load(c - 2));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl() !== e.c || (e.chk && (o_bit_sel !== e.bs))) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: ctl=%b bit_sel=%0d, expected ctl=%b bit_sel=%0d",
                         c, ctl(), o_bit_sel, e.c, e.bs);
            end
        end
        i_rst = 1'b0;
        n_checks++;
        if (pc_seen !== 4) begin
            n_fail++;
            $display("FAIL reset_mid_pcincr: got %0d, expected 4", pc_seen);
        end
    endtask

`ifdef SERIAL_CTRL_STEP_EN
    // Two single-step NOPs 10 cycles apart with i_run low.
    task automatic test_step();
        exp_t e;
        i_run = 1'b0; i_fetch_ack = 1'b1; i_instr = 2'b00;
        for (int c = 0; c < 20; c++) begin
            i_step = ((c % 10) == 0);
            if ((c % 10) == 0)      exp_q.push_back(mk(C_FETCH, 0, 1'b0));
            else if ((c % 10) == 1) exp_q.push_back(mk(C_BUSY | C_PC, 0, 1'b1));
            else                    exp_q.push_back(mk(C_IDLE, 0, 1'b0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ctl() !== e.c || (e.chk && (o_bit_sel !== e.bs))) begin
                n_fail++;
                $display("FAIL step c%0d: ctl=%b bit_sel=%0d, expected ctl=%b bit_sel=%0d",
                         c, ctl(), o_bit_sel, e.c, e.bs);
            end
        end
        i_step = 1'b0;
        n_checks++;
        if (pc_seen !== 6) begin
            n_fail++;
            $display("FAIL step_pcincr: got %0d, expected 6", pc_seen);
        end
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        pc_seen     = 0;
        i_rst       = 1'b1;
        i_run       = 1'b0;
        i_fetch_ack = 1'b0;
        i_instr     = 2'b00;
`ifdef SERIAL_CTRL_STEP_EN
        i_step      = 1'b0;
`endif
        test_reset();
        test_load();
        test_add_delayed();
        test_nop_halt();
        test_reset_mid();
`ifdef SERIAL_CTRL_STEP_EN
        test_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
